// File: rtl/uart_rx_axis_packer.sv
// UART byte packer: turns a strobed UART byte stream into AXI-Stream packets.
// A packet closes when it reaches MAX_PKT bytes or when the line has been idle
// for IDLE_TIMEOUT clocks. The newest byte waits in a pending register until
// its tlast is known, and then goes into a first-word-fall-through FIFO.
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   rx_data/rx_valid  byte strobe from the UART receiver
//   m_axis_*          AXI-Stream master (data, valid, ready, last)
//   overflow          one-clock pulse when a byte is dropped on a full FIFO
//   drop_count        dropped-byte count, saturating at 255
//   fill_level        FIFO occupancy, 0..DEPTH
module uart_rx_axis_packer #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int MAX_PKT      = 64,
    parameter int IDLE_TIMEOUT = 4340
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic [WIDTH-1:0]         m_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic [LW-1:0]    len;
    logic [TW-1:0]    timer;
    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic len_max;
    logic tmo;
    logic push_req;
    logic push_last;
    logic room;
    logic push;
    logic pop;

    assign len_max  = (len == LW'(MAX_PKT));
    assign tmo      = (timer == TW'(IDLE_TIMEOUT - 1));

    // A new byte closes the pending one only on length; a timeout always
    // closes it. rx_valid wins over a coincident timeout.
    assign push_req  = (state == HOLD) && (rx_valid || tmo);
    assign push_last = rx_valid ? len_max : 1'b1;

    // Room is judged on the current occupancy, ignoring a same-cycle pop.
    assign room = (count < CW'(DEPTH));
    assign push = push_req && room;
    assign pop  = (count != '0) && m_axis_ready;

    assign m_axis_valid = (count != '0);
    assign m_axis_data  = m_axis_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid ? mem[rd_ptr][WIDTH] : 1'b0;
    assign fill_level   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_last, pend};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= '0;
            len        <= '0;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push_req && !room;
            if (push_req && !room && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            unique case (state)
                IDLE: begin
                    if (rx_valid) begin
                        pend  <= rx_data;
                        len   <= LW'(1);
                        timer <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (rx_valid) begin
                        pend  <= rx_data;
                        timer <= '0;
                        len   <= len_max ? LW'(1) : len + 1'b1;
                    end else if (tmo) begin
                        len   <= '0;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Self-checking bench for uart_rx_axis_packer: directed packet scenarios
// plus randomized traffic, compared cycle by cycle with a time-based model.
module tb_uart_rx_axis_packer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int MP = 4;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [W-1:0] m_axis_data;
    logic         m_axis_valid;
    logic         m_axis_ready = 1'b0;
    logic         m_axis_last;
    logic         overflow;
    logic [7:0]   drop_count;
    logic [2:0]   fill_level;

    uart_rx_axis_packer #(
        .WIDTH(W), .DEPTH(D), .MAX_PKT(MP), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
        .overflow(overflow), .drop_count(drop_count),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a queue of {last,data}, the pending byte, its packet length
    // and the edge index of the most recent received byte.
    typedef struct packed {
        logic         l;
        logic [W-1:0] d;
    } ent_t;

    ent_t         q[$];
    bit           m_pend = 0;
    logic [W-1:0] m_pdata = '0;
    int           m_plen = 0;
    longint       cyc = 0;
    longint       m_last_rx = 0;
    int           m_drops = 0;
    bit           m_ovf = 0;
    int           ovf_seen = 0;

    task automatic model(bit v, logic [W-1:0] d, bit rdy, bit r);
        bit   pop;
        bit   do_push;
        bit   plast;
        int   sz;
        ent_t e;
        if (r) begin
            q.delete();
            m_pend = 0;
            m_plen = 0;
            m_drops = 0;
            m_ovf = 0;
            return;
        end
        pop = (q.size() > 0) && rdy;
        do_push = 0;
        plast = 0;
        m_ovf = 0;
        if (m_pend) begin
            if (v) begin
                do_push = 1;
                plast = (m_plen == MP);
            end else if (cyc - m_last_rx == TO) begin
                do_push = 1;
                plast = 1;
                m_pend = 0;
                m_plen = 0;
            end
        end
        sz = q.size();
        if (pop) e = q.pop_front();
        if (do_push) begin
            if (sz < D) begin
                e.l = plast;
                e.d = m_pdata;
                q.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (v) begin
            m_plen = m_pend ? ((m_plen == MP) ? 1 : m_plen + 1) : 1;
            m_pdata = d;
            m_pend = 1;
            m_last_rx = cyc;
        end
    endtask

    task automatic step(bit v, logic [W-1:0] d, bit rdy, bit r);
        @(negedge clk);
        chk("valid", m_axis_valid, q.size() != 0);
        chk("data", m_axis_data, (q.size() != 0) ? q[0].d : 8'h00);
        chk("last", m_axis_last, (q.size() != 0) ? q[0].l : 1'b0);
        chk("fill", fill_level, q.size());
        chk("ovf", overflow, m_ovf);
        chk("drops", drop_count, m_drops);
        if (overflow === 1'b1) ovf_seen++;
        rst = r;
        rx_valid = v;
        rx_data = d;
        m_axis_ready = rdy;
        model(v, d, rdy, r);
        cyc++;
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) step(0, '0, rdy, 0);
    endtask

    int lat;
    int pct_rx;
    int pct_rdy;

    initial begin
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // three bytes five clocks apart; last byte closes on timeout
        step(1, 8'h11, 1, 0);
        idle(4, 1);
        step(1, 8'h22, 1, 0);
        idle(4, 1);
        step(1, 8'h33, 1, 0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step(0, '0, 1, 0);
            if (lat < 0 && m_axis_valid === 1'b1 && m_axis_data === 8'h33)
                lat = k;
        end
        chk("lat34", lat, 21);

        // six bytes every two clocks: length close then timeout close
        for (int i = 1; i <= 6; i++) begin
            step(1, 8'hA0 + 8'(i), 1, 0);
            idle(1, 1);
        end
        idle(25, 1);

        // blocked sink, six single-byte packets, two dropped
        step(0, '0, 0, 1);
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 8'hC0 + 8'(i), 0, 0);
            idle(24, 0);
        end
        chk("fill36", fill_level, 4);
        chk("drop36", drop_count, 2);
        chk("ovfn36", ovf_seen, 2);
        idle(8, 1);
        chk("empty36", fill_level, 0);

        // second byte 19 clocks later, then exactly on the timeout cycle
        step(1, 8'h55, 1, 0);
        idle(18, 1);
        step(1, 8'h66, 1, 0);
        idle(25, 1);
        step(1, 8'h5A, 1, 0);
        idle(19, 1);
        step(1, 8'h6A, 1, 0);
        idle(25, 1);

        // reset in the middle of a packet
        step(1, 8'h01, 1, 0);
        step(1, 8'h02, 1, 0);
        step(0, '0, 1, 1);
        step(0, '0, 1, 0);
        chk("rst_val", m_axis_valid, 0);
        chk("rst_fill", fill_level, 0);
        step(1, 8'h77, 1, 0);
        idle(25, 1);

        // full FIFO with a simultaneous push and pop
        step(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hE0 + 8'(i), 0, 0);
            idle(24, 0);
        end
        step(1, 8'h88, 0, 0);
        step(1, 8'h99, 1, 0);
        step(0, '0, 0, 0);
        chk("ovf39", overflow, 1);
        chk("fill39", fill_level, 3);
        idle(30, 1);

        // randomized traffic
        step(0, '0, 1, 1);
        pct_rx = 30;
        pct_rdy = 70;
        for (int c = 0; c < 5000; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct_rx = 2;
                    1: pct_rx = 20;
                    2: pct_rx = 60;
                    default: pct_rx = 0;
                endcase
                pct_rdy = $urandom_range(0, 100);
            end
            step($urandom_range(0, 99) < pct_rx, 8'($urandom),
                 $urandom_range(0, 99) < pct_rdy,
                 $urandom_range(0, 999) == 0);
        end
        idle(30, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
